// File: rtl/motor_ramp_ctrl.sv
// motor_ramp_ctrl: soft-start/soft-stop sequencer feeding the motor driver pin.
// Turns the run request into a ramped PWM duty, enforces a minimum off-time
// after every stop, and latches external faults until they are acknowledged.
module motor_ramp_ctrl #(
  parameter int PWM_BITS      = 8,
  parameter int DUTY_MAX      = 255,
  parameter int RAMP_STEP     = 8,
  parameter int MIN_OFF_TICKS = 50
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                tick_ramp,
  input  logic                motor_req,
  input  logic                fault_in,
  input  logic                fault_clr,
  output logic                pwm_out,
  output logic [PWM_BITS-1:0] duty_val,
  output logic                motor_active,
  output logic                fault_latched,
  output logic [2:0]          state_dbg
);

  localparam int HO_W = $clog2(MIN_OFF_TICKS + 1);

  localparam logic [PWM_BITS-1:0] DUTY_FULL = PWM_BITS'(DUTY_MAX);
  localparam logic [PWM_BITS-1:0] CNT_LAST  = PWM_BITS'(DUTY_MAX - 1);
  localparam logic [PWM_BITS-1:0] STEP_N    = PWM_BITS'(RAMP_STEP);
  localparam logic [PWM_BITS:0]   STEP_EXT  = (PWM_BITS + 1)'(RAMP_STEP);
  localparam logic [PWM_BITS:0]   FULL_EXT  = (PWM_BITS + 1)'(DUTY_MAX);
  localparam logic [HO_W-1:0]     HOLD_LOAD = HO_W'(MIN_OFF_TICKS);
  localparam logic [HO_W-1:0]     HOLD_ONE  = HO_W'(1);

  localparam logic [2:0] ST_OFF       = 3'd0;
  localparam logic [2:0] ST_RAMP_UP   = 3'd1;
  localparam logic [2:0] ST_ON        = 3'd2;
  localparam logic [2:0] ST_RAMP_DOWN = 3'd3;
  localparam logic [2:0] ST_HOLDOFF   = 3'd4;
  localparam logic [2:0] ST_FAULT     = 3'd5;

  logic [2:0]          state, state_nx;
  logic [PWM_BITS-1:0] duty_reg, duty_nx;
  logic [PWM_BITS-1:0] duty_active;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [HO_W-1:0]     holdoff_cnt, holdoff_nx;
  logic                pwm_q;
  logic                pwm_wrap;
  logic                fault_entry;
  logic [PWM_BITS:0]   up_sum;

  // The sum is one bit wider than the duty so saturation can see the carry.
  assign up_sum      = {1'b0, duty_reg} + STEP_EXT;
  assign pwm_wrap    = (pwm_cnt >= CNT_LAST);
  assign fault_entry = fault_in && (state != ST_FAULT);

  // Next-state, duty and holdoff decisions; fault pre-empts request and tick.
  always_comb begin
    state_nx   = state;
    duty_nx    = duty_reg;
    holdoff_nx = holdoff_cnt;
    if (fault_entry) begin
      state_nx = ST_FAULT;
      duty_nx  = '0;
    end else begin
      case (state)
        ST_OFF: begin
          duty_nx = '0;
          if (motor_req) state_nx = ST_RAMP_UP;
        end
        ST_RAMP_UP: begin
          if (!motor_req) begin
            state_nx = ST_RAMP_DOWN;
          end else if (tick_ramp) begin
            if (up_sum >= FULL_EXT) begin
              duty_nx  = DUTY_FULL;
              state_nx = ST_ON;
            end else begin
              duty_nx = up_sum[PWM_BITS-1:0];
            end
          end
        end
        ST_ON: begin
          duty_nx = DUTY_FULL;
          if (!motor_req) state_nx = ST_RAMP_DOWN;
        end
        ST_RAMP_DOWN: begin
          if (motor_req) begin
            state_nx = ST_RAMP_UP;
          end else if (tick_ramp) begin
            if ({1'b0, duty_reg} <= STEP_EXT) begin
              duty_nx    = '0;
              state_nx   = ST_HOLDOFF;
              holdoff_nx = HOLD_LOAD;
            end else begin
              duty_nx = duty_reg - STEP_N;
            end
          end
        end
        ST_HOLDOFF: begin
          duty_nx = '0;
          if (tick_ramp) begin
            if (holdoff_cnt <= HOLD_ONE) begin
              holdoff_nx = '0;
              state_nx   = ST_OFF;
            end else begin
              holdoff_nx = holdoff_cnt - HOLD_ONE;
            end
          end
        end
        ST_FAULT: begin
          duty_nx = '0;
          if (fault_clr && !fault_in) begin
            state_nx   = ST_HOLDOFF;
            holdoff_nx = HOLD_LOAD;
          end
        end
        default: begin
          state_nx   = ST_OFF;
          duty_nx    = '0;
          holdoff_nx = '0;
        end
      endcase
    end
  end

  // Sequencer registers: state, target duty and off-time counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= ST_OFF;
      duty_reg    <= '0;
      holdoff_cnt <= '0;
    end else begin
      state       <= state_nx;
      duty_reg    <= duty_nx;
      holdoff_cnt <= holdoff_nx;
    end
  end

  // PWM period counter plus the active duty, which only changes at a period
  // boundary so a ramp step never produces a runt or stretched pulse.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pwm_cnt     <= '0;
      duty_active <= '0;
      pwm_q       <= 1'b0;
    end else begin
      pwm_cnt <= pwm_wrap ? '0 : pwm_cnt + 1'b1;
      if (fault_entry) begin
        duty_active <= '0;
      end else if (pwm_wrap) begin
        duty_active <= duty_reg;
      end
      pwm_q <= (pwm_cnt < duty_active) && !fault_in && (state != ST_FAULT);
    end
  end

  assign pwm_out       = pwm_q;
  assign duty_val      = duty_reg;
  assign motor_active  = (state == ST_RAMP_UP) || (state == ST_ON) || (state == ST_RAMP_DOWN);
  assign fault_latched = (state == ST_FAULT);
  assign state_dbg     = state;

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// tb_motor_ramp_ctrl: scoreboard bench for motor_ramp_ctrl. Each driven cycle
// pushes the reference model's expected outputs; a monitor pops and compares.
module tb_motor_ramp_ctrl;

  localparam int PB   = 8;
  localparam int DM   = 100;
  localparam int STEP = 30;
  localparam int HOLD = 3;

  localparam int S_OFF   = 0;
  localparam int S_UP    = 1;
  localparam int S_ON    = 2;
  localparam int S_DOWN  = 3;
  localparam int S_HOLD  = 4;
  localparam int S_FAULT = 5;

  typedef struct packed {
    logic          pwm;
    logic [PB-1:0] duty;
    logic          act;
    logic          lat;
    logic [2:0]    st;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          tick_ramp = 1'b0;
  logic          motor_req = 1'b0;
  logic          fault_in = 1'b0;
  logic          fault_clr = 1'b0;
  logic          pwm_out;
  logic [PB-1:0] duty_val;
  logic          motor_active;
  logic          fault_latched;
  logic [2:0]    state_dbg;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cycle = 0;

  // Reference model state, in plain integers.
  int m_state = S_OFF;
  int m_duty = 0;
  int m_active = 0;
  int m_phase = 0;
  int m_hold = 0;

  motor_ramp_ctrl #(
    .PWM_BITS(PB), .DUTY_MAX(DM), .RAMP_STEP(STEP), .MIN_OFF_TICKS(HOLD)
  ) dut (
    .clk(clk), .reset_n(reset_n), .tick_ramp(tick_ramp), .motor_req(motor_req),
    .fault_in(fault_in), .fault_clr(fault_clr), .pwm_out(pwm_out),
    .duty_val(duty_val), .motor_active(motor_active),
    .fault_latched(fault_latched), .state_dbg(state_dbg)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Advance the behavioural model by one clock edge and return post-edge outputs.
  task automatic modelStep(input bit rst_n, input bit tick, input bit req,
                           input bit flt, input bit clr, output exp_t e);
    bit pw;
    pw = 1'b0;
    if (!rst_n) begin
      m_state = S_OFF; m_duty = 0; m_active = 0; m_phase = 0; m_hold = 0;
    end else begin
      pw = (m_phase < m_active) && !flt && (m_state != S_FAULT);
      if (m_phase == DM - 1) m_active = m_duty;
      m_phase = (m_phase + 1) % DM;
      if (flt && m_state != S_FAULT) begin
        m_state = S_FAULT; m_duty = 0; m_active = 0;
      end else begin
        case (m_state)
          S_OFF:  if (req) m_state = S_UP;
          S_UP: begin
            if (!req) m_state = S_DOWN;
            else if (tick) begin
              m_duty = (m_duty + STEP > DM) ? DM : m_duty + STEP;
              if (m_duty == DM) m_state = S_ON;
            end
          end
          S_ON:   if (!req) m_state = S_DOWN;
          S_DOWN: begin
            if (req) m_state = S_UP;
            else if (tick) begin
              m_duty = (m_duty > STEP) ? m_duty - STEP : 0;
              if (m_duty == 0) begin m_state = S_HOLD; m_hold = HOLD; end
            end
          end
          S_HOLD: begin
            if (tick) begin
              m_hold = m_hold - 1;
              if (m_hold == 0) m_state = S_OFF;
            end
          end
          default: begin
            if (clr && !flt) begin m_state = S_HOLD; m_hold = HOLD; end
          end
        endcase
      end
    end
    e.pwm  = pw;
    e.duty = PB'(m_duty);
    e.act  = (m_state == S_UP) || (m_state == S_ON) || (m_state == S_DOWN);
    e.lat  = (m_state == S_FAULT);
    e.st   = 3'(m_state);
  endtask

  // Drive one cycle of inputs, queue the expected response, return just after the edge.
  task automatic applyStimulus(input bit rst_n, input bit tick, input bit req,
                               input bit flt, input bit clr);
    exp_t e;
    @(negedge clk);
    reset_n = rst_n; tick_ramp = tick; motor_req = req; fault_in = flt; fault_clr = clr;
    modelStep(rst_n, tick, req, flt, clr, e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    tick_ramp = 1'b0; fault_clr = 1'b0;
  endtask

  // Directed spot check against a constant taken from the scenario description.
  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  task automatic idle(input int n, input bit req);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, req, 1'b0, 1'b0);
  endtask

  task automatic countHigh(input int n, input bit req, output int highs);
    highs = 0;
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, 1'b0, req, 1'b0, 1'b0);
      if (pwm_out) highs++;
    end
  endtask

  // Scoreboard monitor: after every edge, pop the expected record and compare.
  initial begin
    exp_t e;
    exp_t got;
    forever begin
      @(posedge clk);
      #2;
      cycle++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got = '{pwm: pwm_out, duty: duty_val, act: motor_active,
                lat: fault_latched, st: state_dbg};
        vectors++;
        if (got !== e) begin
          miscompares++;
          $display("[TB] FAIL scoreboard cycle %0d: got pwm=%0b duty=%0d act=%0b lat=%0b st=%0d, expected pwm=%0b duty=%0d act=%0b lat=%0b st=%0d",
                   cycle, got.pwm, got.duty, got.act, got.lat, got.st,
                   e.pwm, e.duty, e.act, e.lat, e.st);
        end
      end
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #5_000_000;
    $display("[TB] FAIL timeout: simulation exceeded time limit, got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

  // Directed scenarios first, then a randomized soak.
  initial begin
    int highs;
    bit req_lvl, flt_lvl;
    int flt_left;

    // Reset held with a pending request.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("reset_pwm", pwm_out, 0);
    checkOutput("reset_duty", duty_val, 0);
    checkOutput("reset_active", motor_active, 0);
    checkOutput("reset_latched", fault_latched, 0);
    checkOutput("reset_state", state_dbg, S_OFF);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("release_state", state_dbg, S_UP);

    // Ramp up to saturation.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0); checkOutput("up_1", duty_val, 30); idle(2, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0); checkOutput("up_2", duty_val, 60); idle(2, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0); checkOutput("up_3", duty_val, 90); idle(2, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0); checkOutput("up_sat", duty_val, 100);
    checkOutput("up_on_state", state_dbg, S_ON);
    idle(DM + 5, 1'b1);
    countHigh(DM, 1'b1, highs);
    checkOutput("full_duty_highs", highs, DM);

    // Ramp down into holdoff; request raised during holdoff is deferred.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); checkOutput("down_state", state_dbg, S_DOWN);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); checkOutput("down_1", duty_val, 70); idle(1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); checkOutput("down_2", duty_val, 40); idle(1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); checkOutput("down_3", duty_val, 10); idle(1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); checkOutput("down_0", duty_val, 0);
    checkOutput("holdoff_entry", state_dbg, S_HOLD);
    idle(2, 1'b1);
    checkOutput("holdoff_ignores_req", state_dbg, S_HOLD);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0); idle(1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0); checkOutput("holdoff_mid", state_dbg, S_HOLD);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0); checkOutput("holdoff_exit", state_dbg, S_OFF);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0); checkOutput("restart", state_dbg, S_UP);

    // Reversal without holdoff.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0); checkOutput("rev_60", duty_val, 60);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); checkOutput("rev_drop_tick_ignored", duty_val, 60);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); checkOutput("rev_30", duty_val, 30);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0); checkOutput("rev_up_state", state_dbg, S_UP);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0); checkOutput("rev_back_60", duty_val, 60);

    // Settle at duty 30 and measure one full period.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(2 * DM, 1'b1);
    countHigh(DM, 1'b1, highs);
    checkOutput("duty30_highs", highs, 30);
    idle(37, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(2 * DM + 10, 1'b1);

    // Fault while ON, ignored clear, then proper clear into holdoff.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("pre_fault_on", state_dbg, S_ON);
    idle(5, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("fault_pwm", pwm_out, 0);
    checkOutput("fault_duty", duty_val, 0);
    checkOutput("fault_latched", fault_latched, 1);
    checkOutput("fault_state", state_dbg, S_FAULT);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("fault_clr_blocked", state_dbg, S_FAULT);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("fault_clr_holdoff", state_dbg, S_HOLD);
    for (int i = 0; i < HOLD; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(1, 1'b0);
    end
    checkOutput("fault_recover_off", state_dbg, S_OFF);

    // Randomized soak against the model.
    req_lvl = 1'b0; flt_lvl = 1'b0; flt_left = 0;
    for (int i = 0; i < 5000; i++) begin
      bit rst_n, tk, clr;
      if ($urandom_range(0, 39) == 0) req_lvl = ~req_lvl;
      if (flt_left > 0) begin
        flt_left--;
        if (flt_left == 0) flt_lvl = 1'b0;
      end else if ($urandom_range(0, 299) == 0) begin
        flt_lvl = 1'b1;
        flt_left = $urandom_range(1, 30);
      end
      rst_n = ($urandom_range(0, 999) != 0);
      tk    = ($urandom_range(0, 5) == 0);
      clr   = ($urandom_range(0, 9) == 0);
      applyStimulus(rst_n, tk, req_lvl, flt_lvl, clr);
    end

    // Drain: every queued expectation must have been consumed.
    @(posedge clk);
    #3;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
